z_row_argmax: RTL

Z_ROW_ARGMAX -- requirements
Module: z_row_argmax

---
 rtl/dfr_pkg.sv | 16 +
 rtl/z_row_argmax.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dfr_pkg.sv
// Shared definitions for the Z-matrix datapath: default bus widths and the
// row-argmax controller state encoding.
package dfr_pkg;

    localparam int DFR_ADDR_WIDTH = 32;
    localparam int DFR_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CMP   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } dfr_state_t;

endpackage

// File: rtl/z_row_argmax.sv
// Scans each row of Z (row-major RAM) and writes the column index of the
// largest signed element into the result RAM, one word per row.
module z_row_argmax
    import dfr_pkg::*;
#(
    parameter int ADDR_WIDTH = DFR_ADDR_WIDTH,
    parameter int DATA_WIDTH = DFR_DATA_WIDTH,
    parameter int Z_ROWS     = 5,
    parameter int Z_COLS     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] z_addr,
    input  logic [DATA_WIDTH-1:0] z_data,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_wen,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(Z_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(Z_ROWS - 1);

    dfr_state_t state, state_d;

    logic        [ADDR_WIDTH-1:0] row, row_d;
    logic        [ADDR_WIDTH-1:0] col, col_d;
    logic signed [DATA_WIDTH-1:0] max_v, max_d;
    logic        [DATA_WIDTH-1:0] best, best_d;
    logic signed [DATA_WIDTH-1:0] z_s;
    logic        [ADDR_WIDTH-1:0] z_addr_d;
    logic        [ADDR_WIDTH-1:0] res_addr_d;
    logic        [DATA_WIDTH-1:0] res_data_d;
    logic                         res_wen_d;
    logic                         busy_d;
    logic                         done_d;
    logic                         take;

    assign z_s  = z_data;
    // First column always seeds the running max; later ones must be strictly larger.
    assign take = (col == '0) || (z_s > max_v);

    always_comb begin
        state_d    = state;
        row_d      = row;
        col_d      = col;
        max_d      = max_v;
        best_d     = best;
        z_addr_d   = z_addr;
        res_addr_d = res_addr;
        res_data_d = res_data;
        res_wen_d  = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    row_d    = '0;
                    col_d    = '0;
                    max_d    = '0;
                    best_d   = '0;
                    z_addr_d = '0;
                    busy_d   = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                state_d = CMP;
            end
            CMP: begin
                if (take) begin
                    max_d  = z_s;
                    best_d = DATA_WIDTH'(col);
                end
                if (col == LAST_COL) begin
                    res_wen_d  = 1'b1;
                    res_addr_d = row;
                    res_data_d = take ? DATA_WIDTH'(col) : best;
                    state_d    = WRITE;
                end else begin
                    col_d    = col + ADDR_WIDTH'(1);
                    z_addr_d = z_addr + ADDR_WIDTH'(1);
                    state_d  = FETCH;
                end
            end
            WRITE: begin
                if (row == LAST_ROW) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    row_d    = row + ADDR_WIDTH'(1);
                    col_d    = '0;
                    z_addr_d = z_addr + ADDR_WIDTH'(1);
                    state_d  = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            max_v    <= '0;
            best     <= '0;
            z_addr   <= '0;
            res_addr <= '0;
            res_data <= '0;
            res_wen  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            row      <= row_d;
            col      <= col_d;
            max_v    <= max_d;
            best     <= best_d;
            z_addr   <= z_addr_d;
            res_addr <= res_addr_d;
            res_data <= res_data_d;
            res_wen  <= res_wen_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule
